// File: rtl/cp0_regs.sv
// MIPS CP0 subset: Status, Cause, EPC, BadVAddr and optional Count/Compare timer.
// Define CP0_TIMER_INT_EN to build the Count/Compare timer and its TI interrupt.
module cp0_regs (
    input  logic        clock,
    input  logic        reset,
    input  logic        pipe5_valid,
    input  logic [5:0]  ex,
    input  logic        inst_ERET,
    input  logic [31:0] pc_wb,
    input  logic        in_delay_slot,
    input  logic [31:0] badvaddr_in,
    input  logic        mtc0_we,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] wdata,
    input  logic [5:0]  hw_int,
    output logic [31:0] rdata,
    output logic [31:0] cp0_value,
    output logic        int_pending,
    output logic        status_exl
);

    localparam logic [4:0] ADDR_BADVADDR = 5'd8;
    localparam logic [4:0] ADDR_COUNT    = 5'd9;
    localparam logic [4:0] ADDR_COMPARE  = 5'd11;
    localparam logic [4:0] ADDR_STATUS   = 5'd12;
    localparam logic [4:0] ADDR_CAUSE    = 5'd13;
    localparam logic [4:0] ADDR_EPC      = 5'd14;

    localparam logic [4:0] CODE_INT  = 5'h00;
    localparam logic [4:0] CODE_ADEL = 5'h04;
    localparam logic [4:0] CODE_ADES = 5'h05;
    localparam logic [4:0] CODE_RI   = 5'h0a;
    localparam logic [4:0] CODE_OV   = 5'h0c;
    localparam logic [4:0] CODE_SYS  = 5'h08;

    logic        ex_commit;
    logic        eret_commit;
    logic        mtc0_commit;
    logic [4:0]  exc_code_sel;
    logic        exc_is_addr;

    logic [7:0]  status_im_reg;
    logic        status_exl_reg;
    logic        status_ie_reg;
    logic        cause_bd_reg;
    logic [1:0]  cause_ip_sw_reg;
    logic [4:0]  cause_exc_reg;
    logic [31:0] epc_reg;
    logic [31:0] badvaddr_reg;

    logic        cause_ti;
    logic [31:0] count_val;
    logic [31:0] compare_val;
    logic [7:0]  cause_ip;
    logic [31:0] status_val;
    logic [31:0] cause_val;

    assign ex_commit   = pipe5_valid & (|ex);
    assign eret_commit = pipe5_valid & inst_ERET & ~(|ex);
    assign mtc0_commit = pipe5_valid & mtc0_we & ~(|ex);

    // Lowest bit index wins; only AdEL/AdES capture the faulting address.
    always_comb begin
        exc_code_sel = CODE_INT;
        exc_is_addr  = 1'b0;
        if (ex[0]) begin
            exc_code_sel = CODE_INT;
        end else if (ex[1]) begin
            exc_code_sel = CODE_ADEL;
            exc_is_addr  = 1'b1;
        end else if (ex[2]) begin
            exc_code_sel = CODE_ADES;
            exc_is_addr  = 1'b1;
        end else if (ex[3]) begin
            exc_code_sel = CODE_RI;
        end else if (ex[4]) begin
            exc_code_sel = CODE_OV;
        end else if (ex[5]) begin
            exc_code_sel = CODE_SYS;
        end
    end

`ifdef CP0_TIMER_INT_EN
    logic [31:0] count_reg;
    logic [31:0] compare_reg;
    logic        tick_reg;
    logic        cause_ti_reg;
    logic [31:0] count_inc;
    logic        count_write;
    logic        compare_write;

    assign count_inc     = count_reg + 32'd1;
    assign count_write   = mtc0_commit && (cp0_addr == ADDR_COUNT);
    assign compare_write = mtc0_commit && (cp0_addr == ADDR_COMPARE);

    // Count advances every other cycle; a software write replaces that cycle's step.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_reg    <= '0;
            compare_reg  <= '0;
            tick_reg     <= 1'b0;
            cause_ti_reg <= 1'b0;
        end else begin
            tick_reg <= ~tick_reg;
            if (count_write) begin
                count_reg <= wdata;
            end else if (tick_reg) begin
                count_reg <= count_inc;
            end
            if (compare_write) begin
                compare_reg  <= wdata;
                cause_ti_reg <= 1'b0;
            end else if (tick_reg && !count_write && (count_inc == compare_reg)) begin
                cause_ti_reg <= 1'b1;
            end
        end
    end

    assign cause_ti    = cause_ti_reg;
    assign count_val   = count_reg;
    assign compare_val = compare_reg;
`else
    assign cause_ti    = 1'b0;
    assign count_val   = '0;
    assign compare_val = '0;
`endif

    // Exception updates are placed after MTC0 updates so they win on shared fields.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            status_im_reg   <= '0;
            status_exl_reg  <= 1'b0;
            status_ie_reg   <= 1'b0;
            cause_bd_reg    <= 1'b0;
            cause_ip_sw_reg <= '0;
            cause_exc_reg   <= '0;
            epc_reg         <= '0;
            badvaddr_reg    <= '0;
        end else begin
            if (mtc0_commit) begin
                case (cp0_addr)
                    ADDR_STATUS: begin
                        status_im_reg  <= wdata[15:8];
                        status_exl_reg <= wdata[1];
                        status_ie_reg  <= wdata[0];
                    end
                    ADDR_CAUSE: cause_ip_sw_reg <= wdata[9:8];
                    ADDR_EPC:   epc_reg         <= wdata;
                    default: ;
                endcase
            end
            if (eret_commit) begin
                status_exl_reg <= 1'b0;
            end
            if (ex_commit) begin
                status_exl_reg <= 1'b1;
                cause_exc_reg  <= exc_code_sel;
                if (!status_exl_reg) begin
                    epc_reg      <= in_delay_slot ? (pc_wb - 32'd4) : pc_wb;
                    cause_bd_reg <= in_delay_slot;
                end
                if (exc_is_addr) begin
                    badvaddr_reg <= badvaddr_in;
                end
            end
        end
    end

    assign cause_ip   = {hw_int[5] | cause_ti, hw_int[4:0], cause_ip_sw_reg};
    assign status_val = {9'b0, 1'b1, 6'b0, status_im_reg, 6'b0, status_exl_reg, status_ie_reg};
    assign cause_val  = {cause_bd_reg, cause_ti, 14'b0, cause_ip, 1'b0, cause_exc_reg, 2'b0};

    always_comb begin
        rdata = '0;
        case (cp0_addr)
            ADDR_BADVADDR: rdata = badvaddr_reg;
            ADDR_COUNT:    rdata = count_val;
            ADDR_COMPARE:  rdata = compare_val;
            ADDR_STATUS:   rdata = status_val;
            ADDR_CAUSE:    rdata = cause_val;
            ADDR_EPC:      rdata = epc_reg;
            default:       rdata = '0;
        endcase
    end

    assign cp0_value   = epc_reg;
    assign status_exl  = status_exl_reg;
    assign int_pending = status_ie_reg & ~status_exl_reg & (|(cause_ip & status_im_reg));

endmodule

// File: doc/cp0_regs.md
CP0_REGS -- requirements
Module: cp0_regs

Interface
REQ-001 clock  in  1  pipeline clock; all state updates on rising edge.
REQ-002 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-003 pipe5_valid  in  1  the writeback-stage instruction is valid.
REQ-004 ex  in  6  one-hot-or-more exception flags of the writeback instruction: bit0 Int, bit1 AdEL, bit2 AdES, bit3 RI, bit4 Ov, bit5 Syscall.
REQ-005 inst_ERET  in  1  the writeback instruction is ERET.
REQ-006 pc_wb  in  32  PC of the writeback instruction.
REQ-007 in_delay_slot  in  1  the writeback instruction sits in a branch delay slot.
REQ-008 badvaddr_in  in  32  faulting address for AdEL/AdES.
REQ-009 mtc0_we  in  1  the writeback instruction is MTC0.
REQ-010 cp0_addr  in  5  CP0 register number, select 0 only.
REQ-011 wdata  in  32  MTC0 data.
REQ-012 hw_int  in  6  external interrupt lines, level-sensitive.
REQ-013 rdata  out  32  MFC0 read data, combinational from cp0_addr.
REQ-014 cp0_value  out  32  current EPC, feeding the ERET redirect target.
REQ-015 int_pending  out  1  an interrupt is to be injected as ex[0] by decode.
REQ-016 status_exl  out  1  Status.EXL.

Function
REQ-017 Define ex_commit = pipe5_valid & |ex and eret_commit = pipe5_valid & inst_ERET & ~|ex; ex_commit takes precedence over eret_commit.
REQ-018 Priority: bit0 is highest, bit5 lowest. ExcCode values: Int 0x00, AdEL 0x04, AdES 0x05, RI 0x0a, Ov 0x0c, Sys 0x08.
REQ-019 On ex_commit, Cause.ExcCode is written with the highest-priority code.
REQ-020 On ex_commit with EXL=0: EPC <= in_delay_slot ? pc_wb-4 : pc_wb; Cause.BD <= in_delay_slot.
REQ-021 On ex_commit with EXL=1: EPC and BD are left unchanged.
REQ-022 On every ex_commit, EXL is set to 1 at the next edge.
REQ-023 On ex_commit whose selected code is AdEL or AdES, BadVAddr <= badvaddr_in; it is unchanged otherwise.
REQ-024 On eret_commit, EXL is cleared at the next edge. No other register changes.
REQ-025 MTC0 writes only when pipe5_valid & mtc0_we & ~|ex.
REQ-026 If MTC0 and ex_commit target the same field in the same cycle, the exception update wins.
REQ-027 Register map for MTC0 writes:
- 8 BadVAddr: read-only.
- 9 Count: read/write.
- 11 Compare: read/write; a write also clears Cause.TI.
- 12 Status: writable bits are IM[15:8], EXL[1], IE[0]; BEV[22] reads 1; all other bits read 0.
- 13 Cause: BD[31] and TI[30] are read-only; IP[15:10] read-only, mirroring the lines in REQ-029; IP[9:8] writable; ExcCode[6:2] read-only.
- 14 EPC: read/write.
REQ-028 MFC0 reads of any unlisted address return 0. rdata reflects register state before the current edge; there is no write-through.
REQ-029 Cause.IP[15:10] = {hw_int[5] | TI, hw_int[4:0]}, sampled combinationally.
REQ-030 int_pending = Status.IE & ~EXL & |(Cause.IP[15:8] & Status.IM).
REQ-031 cp0_value = EPC register output. An MTC0 to EPC is visible the next cycle.

Reset
REQ-032 On reset, with no clock edge needed, the registers take these values:
- Status = 0x0040_0000.
- Cause, EPC, BadVAddr, Count, Compare = 0.
- Internal count-tick toggle = 0.
REQ-033 During reset, outputs are: int_pending=0, status_exl=0, cp0_value=0.

Configuration
REQ-034 Macro CP0_TIMER_INT_EN, when defined, enables the timer:
- The tick toggles every cycle; Count increments on cycles where tick=1 and wraps 0xFFFF_FFFF -> 0.
- TI is set when Count == Compare after the increment.
- An MTC0 to Count overrides that cycle's increment.
REQ-035 When CP0_TIMER_INT_EN is undefined:
- Count and Compare read 0 and ignore writes.
- TI stays 0, so IP7 = hw_int[5].

Verification
REQ-036 Reset mid-operation: reset asserted with EXL=1 and EPC=0x1234 -> Status=0x0040_0000 and cp0_value=0 immediately, before any clock edge.
REQ-037 Delay-slot exception: ex=6'b001000 (RI), pc_wb=0xBFC0_0104, in_delay_slot=1, pipe5_valid=1 -> EPC=0xBFC0_0100, BD=1, ExcCode=0x0a, EXL=1.
REQ-038 Priority and BadVAddr: ex=6'b010010 with badvaddr_in=0x0000_0003 -> ExcCode=0x04, BadVAddr=0x0000_0003. A second exception while EXL=1 leaves EPC unchanged.
REQ-039 ERET versus exception: ERET with ex=0 -> EXL 1->0. ERET with ex[5]=1 in the same cycle -> EXL stays 1, ExcCode=0x08.
REQ-040 Software interrupt: MTC0 Status=0x0000_0101, then MTC0 Cause=0x0000_0100 -> int_pending=1 the cycle after the Cause write. pipe5_valid=0 with ex!=0 -> no state change.
REQ-041 Timer (macro defined): Compare=10 -> TI=1 and int_pending=1 (with IM7 and IE set) after 20 cycles. An MTC0 to Compare clears TI.
